// File: rtl/axi4_sram_rd_slave_if.sv
// axi4_sram_rd_slave_if: AXI4 AR/R channel bundle shared by the read slave and its master
interface axi4_sram_rd_slave_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;
    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );
    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi4_sram_rd_slave.sv
// axi4_sram_rd_slave: AXI4 read slave serving FIXED/INCR/WRAP bursts from a 1-cycle-latency SRAM
module axi4_sram_rd_slave #(
    parameter int ID_WIDTH       = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 64,
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                      aclk,
    input  logic                      areset,
    axi4_sram_rd_slave_if.slave       s_axi,
    output logic                      mem_ren,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);
    localparam int LSB = $clog2(DATA_WIDTH / 8);
    localparam int BW  = DATA_WIDTH + 3;

    typedef enum logic {IDLE, BURST} state_t;

    state_t                  state_q, state_d;
    logic                    arready_q, arready_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              len_q, len_d;
    logic [2:0]              size_q, size_d;
    logic [1:0]              burst_q, burst_d;
    logic                    err_q, err_d;
    logic [8:0]              left_q, left_d;
    logic                    pipe_q, pipe_d;
    logic                    pipe_last_q, pipe_last_d;
    logic                    pipe_err_q, pipe_err_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [BW-1:0]           buf_q [2];
    logic [BW-1:0]           buf_d [2];
    logic [ADDR_WIDTH-1:0]   step, mask, addr_inc, addr_next;
    logic [DATA_WIDTH-1:0]   in_data;
    logic [BW-1:0]           in_beat, head;
    logic                    ar_hs, ar_err, issue, push, pop, wpos, last_hs;

    assign ar_hs  = s_axi.arvalid & arready_q;
    assign ar_err = (32'(s_axi.arsize) > LSB) | (s_axi.arburst == 2'b11) |
                    ((s_axi.arburst == 2'b10) && !(s_axi.arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));

    assign step      = ADDR_WIDTH'(1) << size_q;
    assign mask      = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
    assign addr_inc  = addr_q + step;
    assign addr_next = (burst_q == 2'b00) ? addr_q :
                       (burst_q == 2'b10) ? ((addr_q & ~mask) | (addr_inc & mask)) : addr_inc;

    // A beat may issue only while the read in flight plus buffered beats leave a free slot
    assign issue    = (state_q == BURST) && (left_q != 9'd0) && ((2'(pipe_q) + cnt_q) < 2'd2);
    assign mem_ren  = issue & ~err_q;
    assign mem_addr = addr_q[LSB +: MEM_ADDR_WIDTH];

    // Returning read data flows straight to R when the buffer is empty, giving 2-cycle latency
    assign in_data = pipe_err_q ? '0 : mem_rdata;
    assign in_beat = pipe_q ? {pipe_last_q, pipe_err_q, 1'b0, in_data} : '0;
    assign head    = (cnt_q == 2'd0) ? in_beat : buf_q[0];

    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = pipe_q | (cnt_q != 2'd0);
    assign s_axi.rid     = id_q;
    assign s_axi.rdata   = head[DATA_WIDTH-1:0];
    assign s_axi.rresp   = head[DATA_WIDTH +: 2];
    assign s_axi.rlast   = head[BW-1];

    assign pop     = (cnt_q != 2'd0) & s_axi.rready;
    assign push    = pipe_q & ~((cnt_q == 2'd0) & s_axi.rready);
    assign wpos    = (cnt_q == 2'd1) & ~pop;
    assign last_hs = s_axi.rvalid & s_axi.rready & s_axi.rlast;

    // Next-state: burst capture, address/beat advance, and skid-buffer bookkeeping
    always_comb begin
        state_d     = (state_q == IDLE) ? (ar_hs ? BURST : IDLE) : (last_hs ? IDLE : BURST);
        arready_d   = (state_d == IDLE);
        id_d        = ar_hs ? s_axi.arid : id_q;
        len_d       = ar_hs ? s_axi.arlen : len_q;
        size_d      = ar_hs ? s_axi.arsize : size_q;
        burst_d     = ar_hs ? s_axi.arburst : burst_q;
        err_d       = ar_hs ? ar_err : err_q;
        addr_d      = ar_hs ? s_axi.araddr : issue ? addr_next : addr_q;
        left_d      = ar_hs ? ({1'b0, s_axi.arlen} + 9'd1) : issue ? (left_q - 9'd1) : left_q;
        pipe_d      = issue;
        pipe_last_d = (left_q == 9'd1);
        pipe_err_d  = err_q;
        cnt_d       = cnt_q + 2'(push) - 2'(pop);
        buf_d       = buf_q;
        if (pop) buf_d[0] = buf_q[1];
        if (push) buf_d[wpos] = in_beat;
    end

    // State registers; reset aborts any burst and empties the buffer
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= IDLE;
            arready_q   <= 1'b0;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            err_q       <= 1'b0;
            left_q      <= '0;
            pipe_q      <= 1'b0;
            pipe_last_q <= 1'b0;
            pipe_err_q  <= 1'b0;
            cnt_q       <= '0;
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
        end else begin
            state_q     <= state_d;
            arready_q   <= arready_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            err_q       <= err_d;
            left_q      <= left_d;
            pipe_q      <= pipe_d;
            pipe_last_q <= pipe_last_d;
            pipe_err_q  <= pipe_err_d;
            cnt_q       <= cnt_d;
            buf_q[0]    <= buf_d[0];
            buf_q[1]    <= buf_d[1];
        end
    end
endmodule
